// File: rtl/nttn_result_unloader_if.sv
// Egress coefficient stream of the NTTN result unloader: one coefficient per
// valid/ready transfer, tagged with its natural-order index.
interface nttn_result_unloader_if #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 10
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [IDX_W-1:0]  m_index;

  modport master (output m_data, m_valid, m_last, m_index, input m_ready);
  modport slave  (input m_data, m_valid, m_last, m_index, output m_ready);
endinterface

// File: rtl/nttn_result_unloader.sv
// Captures a full NTTN result polynomial (2*PE_NUM coefficients per beat, no
// backpressure) into per-lane storage and replays it one word per cycle.

module nttn_unloader_lane #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  // Contents are don't-care after reset, so the storage carries no reset.
  logic [DATA_W-1:0] mem [BEATS];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module nttn_result_unloader #(
  parameter int DATA_W    = 64,
  parameter int PE_NUM    = 8,
  parameter int RING_SIZE = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       done,
  input  logic [2*PE_NUM*DATA_W-1:0] bram_in,
  nttn_result_unloader_if.master     egress,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);
  localparam int LANES = 2 * PE_NUM;
  localparam int BEATS = RING_SIZE / LANES;
  localparam int IDX_W = $clog2(RING_SIZE);
  localparam int BA_W  = $clog2(BEATS);
  localparam int LN_W  = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t                       state, state_nxt;
  logic [BA_W:0]                wr_beat;
  logic [IDX_W-1:0]             rd_idx;
  logic                         done_q;
  logic                         start, xfer, capture, valid_c, last_c, rd_ok;
  logic [BA_W-1:0]              rd_beat;
  logic [LN_W-1:0]              rd_lane;
  logic [31:0]                  avail;
  logic [LANES-1:0][DATA_W-1:0] lane_wr, lane_rd;

  // Packed reshape: lane n lands on bits [DATA_W*n +: DATA_W].
  assign lane_wr = bram_in;
  assign start   = done & ~done_q;

  // A word is readable once its beat has been written; capture outpaces drain.
  assign avail   = 32'(wr_beat) * 32'(LANES);
  assign rd_ok   = 32'(rd_idx) < avail;
  assign rd_beat = BA_W'(rd_idx / IDX_W'(LANES));
  assign rd_lane = LN_W'(rd_idx % IDX_W'(LANES));
  assign last_c  = valid_c & (rd_idx == IDX_W'(RING_SIZE - 1));
  assign xfer    = valid_c & egress.m_ready;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    nttn_unloader_lane #(
      .DATA_W(DATA_W),
      .BEATS (BEATS),
      .AW    (BA_W)
    ) u_lane (
      .clk  (clk),
      .we   (capture),
      .waddr(wr_beat[BA_W-1:0]),
      .wdata(lane_wr[n]),
      .raddr(rd_beat),
      .rdata(lane_rd[n])
    );
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CAPTURE;
      CAPTURE: if (wr_beat == (BA_W+1)'(BEATS - 1)) state_nxt = DRAIN;
      DRAIN:   if (xfer & last_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    capture = 1'b0;
    valid_c = 1'b0;
    case (state)
      CAPTURE: begin
        busy    = 1'b1;
        capture = 1'b1;
        valid_c = rd_ok;
      end
      DRAIN: begin
        busy    = 1'b1;
        valid_c = rd_ok;
      end
      default: ;
    endcase
  end

  assign egress.m_valid = valid_c;
  assign egress.m_last  = last_c;
  assign egress.m_index = rd_idx;
  assign egress.m_data  = valid_c ? lane_rd[rd_lane] : '0;

  // A start seen while busy is dropped but flagged; the running frame continues.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_beat    <= '0;
      rd_idx     <= '0;
      done_q     <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done_q     <= done;
      frame_done <= xfer & last_c;
      if (start & busy) overrun <= 1'b1;
      if ((state == IDLE) & start) begin
        wr_beat <= '0;
        rd_idx  <= '0;
      end else begin
        if (capture) wr_beat <= wr_beat + 1'b1;
        if (xfer)    rd_idx  <= rd_idx + 1'b1;
      end
    end
endmodule
